// File: rtl/nios_cpu_div_cell.sv
// Iterative restoring radix-2 divider for div/divu in the Nios execute stage.
// Fixed WIDTH+2 clock latency: one load cycle, WIDTH shift/subtract steps, one sign-fixup cycle.
module nios_cpu_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] E_src1_div_cell,
    input  logic [WIDTH-1:0] E_src2_div_cell,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;        // dividend magnitude, becomes quotient as it shifts
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] raw_q, raw_d;        // dividend as given, returned on divide-by-zero
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic             s1_neg, s2_neg;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   partial;
    logic             fits;
    logic [WIDTH-1:0] diff_lo;

    assign s1_neg = div_signed & E_src1_div_cell[WIDTH-1];
    assign s2_neg = div_signed & E_src2_div_cell[WIDTH-1];
    assign mag1   = s1_neg ? (~E_src1_div_cell + 1'b1) : E_src1_div_cell;
    assign mag2   = s2_neg ? (~E_src2_div_cell + 1'b1) : E_src2_div_cell;

    // Remainder always stays below the divisor, so only the low WIDTH bits of the
    // difference are meaningful when the subtraction is taken.
    assign partial = {rem_q, dvd_q[WIDTH-1]};
    assign fits    = partial >= {1'b0, dsr_q};
    assign diff_lo = partial[WIDTH-1:0] - dsr_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        dsr_d       = dsr_q;
        raw_d       = raw_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_CALC;
                        cnt_d   = CNT_LOAD;
                        dvd_d   = mag1;
                        dsr_d   = mag2;
                        rem_d   = '0;
                        raw_d   = E_src1_div_cell;
                        q_neg_d = s1_neg ^ s2_neg;
                        r_neg_d = s1_neg;
                    end
                end
                S_CALC: begin
                    rem_d = fits ? diff_lo : partial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], fits};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (dsr_q == '0) begin
                        quotient_d  = '1;
                        remainder_d = raw_q;
                        dbz_d       = 1'b1;
                    end else begin
                        quotient_d  = q_neg_q ? (~dvd_q + 1'b1) : dvd_q;
                        remainder_d = r_neg_q ? (~rem_q + 1'b1) : rem_q;
                        dbz_d       = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            dsr_q       <= '0;
            raw_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            dsr_q       <= dsr_d;
            raw_q       <= raw_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nios_cpu_div_cell.sv
// Self-checking bench for nios_cpu_div_cell: expected results are queued at issue and
// popped when done pulses.
module tb_nios_cpu_div_cell;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;   // edges after the accepting edge until done is seen

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic             div_signed;
    logic [WIDTH-1:0] E_src1_div_cell;
    logic [WIDTH-1:0] E_src2_div_cell;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    nios_cpu_div_cell #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .div_signed      (div_signed),
        .E_src1_div_cell (E_src1_div_cell),
        .E_src2_div_cell (E_src2_div_cell),
        .busy            (busy),
        .done            (done),
        .quotient        (quotient),
        .remainder       (remainder),
        .div_by_zero     (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   tests_run    = 0;
    int   tests_failed = 0;

    function automatic exp_t model(input logic sg, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        int   sa;
        int   sb_;
        e.dbz = 1'b0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000;
                e.r = '0;
            end else begin
                sa  = $signed(a);
                sb_ = $signed(b);
                e.q = sa / sb_;
                e.r = sa % sb_;
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Drive one start pulse; returns just after the accepting edge.
    task automatic issue(input logic sg, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit push);
        div_signed      = sg;
        E_src1_div_cell = a;
        E_src2_div_cell = b;
        start           = 1'b1;
        if (push) sb.push_back(model(sg, a, b));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; abort = 1'b0; div_signed = 1'b0;
        E_src1_div_cell = '0; E_src2_div_cell = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state got busy=%b done=%b q=%h r=%h dbz=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        $display("[TB] reset checked");
    endtask

    task automatic test_unsigned_basic;
        int cyc, busy_cnt;
        bit ok;
        exp_t e;
        issue(1'b0, 32'd100, 32'd7, 1'b1);
        busy_cnt = busy ? 1 : 0;
        cyc = 0; ok = 1'b0;
        while (!ok && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) ok = 1'b1;
        end
        e = sb.pop_front();
        tests_run++;
        if (!ok || cyc != LAT) begin
            tests_failed++;
            $display("FAIL divu_latency got %0d edges (seen=%b) want %0d", cyc, ok, LAT);
        end
        tests_run++;
        if (busy_cnt != 33) begin
            tests_failed++;
            $display("FAIL divu_busy_cycles got %0d want 33", busy_cnt);
        end
        tests_run++;
        if ({quotient, remainder, div_by_zero} !== e) begin
            tests_failed++;
            $display("FAIL divu_100_7 got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                     quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        end
        last_exp = e;
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_one_cycle got done=%b want 0", done);
        end
        $display("[TB] divu 100/7 -> q=%0d r=%0d after %0d edges", quotient, remainder, cyc);
    endtask

    // Table-driven scenarios: signed, divide-by-zero, overflow.
    task automatic test_table(input string name, input logic sg, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [WIDTH-1:0] wq, input logic [WIDTH-1:0] wr, input logic wdbz);
        int cyc;
        bit ok;
        exp_t e;
        issue(sg, a, b, 1'b1);
        wait_done(cyc, ok);
        e = sb.pop_front();
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s_timeout got no done in %0d cycles want done", name, cyc);
        end
        tests_run++;
        if ({quotient, remainder, div_by_zero} !== e || {wq, wr, wdbz} !== e) begin
            tests_failed++;
            $display("FAIL %s got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                     name, quotient, remainder, div_by_zero, wq, wr, wdbz);
        end
        last_exp = e;
        $display("[TB] %s q=%h r=%h dbz=%b", name, quotient, remainder, div_by_zero);
    endtask

    task automatic test_abort;
        int  n_done;
        exp_t old;
        old = last_exp;
        issue(1'b0, 32'd1000, 32'd3, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        E_src1_div_cell = 32'd55; E_src2_div_cell = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignored_start_busy got %b want 1", busy);
        end
        repeat (4) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_busy got %b want 0", busy);
        end
        n_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        tests_run++;
        if (n_done != 0) begin
            tests_failed++;
            $display("FAIL abort_no_done got %0d done pulses want 0", n_done);
        end
        tests_run++;
        if ({quotient, remainder, div_by_zero} !== old) begin
            tests_failed++;
            $display("FAIL abort_outputs_held got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                     quotient, remainder, div_by_zero, old.q, old.r, old.dbz);
        end
        start = 1'b1; abort = 1'b1; E_src1_div_cell = 32'd8; E_src2_div_cell = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_beats_start got busy=%b want 0", busy);
        end
        $display("[TB] abort / ignored start checked");
    endtask

    task automatic test_back_to_back;
        int cyc;
        bit ok;
        exp_t e;
        issue(1'b1, 32'hFFFF_FF9C, 32'd9, 1'b1);          // -100 / 9
        for (int k = 0; k < 2; k++) begin
            wait_done(cyc, ok);
            e = sb.pop_front();
            tests_run++;
            if (!ok || cyc != LAT) begin
                tests_failed++;
                $display("FAIL b2b_latency_%0d got %0d edges (seen=%b) want %0d", k, cyc, ok, LAT);
            end
            tests_run++;
            if ({quotient, remainder, div_by_zero} !== e) begin
                tests_failed++;
                $display("FAIL b2b_result_%0d got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                         k, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
            end
            last_exp = e;
            $display("[TB] back-to-back op %0d q=%h r=%h", k, quotient, remainder);
            if (k == 0) issue(1'b0, 32'd77777, 32'd123, 1'b1);  // start in the done cycle
        end
    endtask

    task automatic test_reset_mid_op;
        int n_done;
        issue(1'b0, 32'd5000, 32'd7, 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_op got busy=%b done=%b q=%h r=%h dbz=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        tests_run++;
        if (n_done != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_op_no_done got %0d pulses want 0", n_done);
        end
        $display("[TB] reset mid-CALC checked");
    endtask

    task automatic test_random_sweep;
        int cyc;
        bit ok;
        exp_t e;
        logic sg;
        logic [WIDTH-1:0] a, b;
        for (int i = 0; i < 24; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(1, 20);
                1:       b = -$urandom_range(1, 20);
                2:       b = $urandom_range(1, 70000);
                default: b = $urandom;
            endcase
            issue(sg, a, b, 1'b1);
            wait_done(cyc, ok);
            e = sb.pop_front();
            tests_run++;
            if (!ok || {quotient, remainder, div_by_zero} !== e) begin
                tests_failed++;
                $display("FAIL sweep_%0d s=%b a=%h b=%h got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                         i, sg, a, b, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
            end
            tests_run++;
            if (quotient * b + remainder !== a) begin
                tests_failed++;
                $display("FAIL sweep_identity_%0d got q*d+r=%h want %h", i, quotient * b + remainder, a);
            end
            $display("[TB] sweep %0d s=%b %h/%h q=%h r=%h", i, sg, a, b, quotient, remainder);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_table("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        test_table("div_7_m2",   1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0);
        test_table("divu_by_0",  1'b0, 32'h1234,      32'd0,         32'hFFFF_FFFF, 32'h1234,      1'b1);
        test_table("divu_9_3",   1'b0, 32'd9,         32'd3,         32'd3,         32'd0,         1'b0);
        test_table("div_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0);
        test_table("divu_ovf",   1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
        test_table("div_m9_by0", 1'b1, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1);
        test_abort();
        test_back_to_back();
        test_reset_mid_op();
        test_random_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
